// File: rtl/spi_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_ctrl
// Purpose  : Frame-level controller between the synchronized SPI byte front
//            end and the PWM/output config bank. Each nCS frame carries a
//            command byte then a data byte. The addressed register is written
//            only when the frame ends cleanly. Short, long, stalled and
//            bad-address frames are rejected and reported in sticky flags.
// Ports    : clk, rst_n (sync, active-low)
//            ncs_fall / ncs_rise / byte_valid : 1-cycle event pulses
//            byte_data [7:0]  : received byte
//            clr_err          : level, clears err_flags
//            en_reg_out_7_0 .. pwm_duty_cycle : config registers, addr 0..4
//            wr_valid         : 1-cycle write strobe
//            wr_addr [2:0]    : address of the last write (held)
//            frame_cnt        : committed writes, wraps
//            err_flags [2:0]  : sticky {timeout, bad_addr, bad_len}
//            busy             : FSM not idle
// Revision : 1.0 - initial release
// ============================================================================
module spi_reg_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 11,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ncs_fall,
    input  logic             ncs_rise,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    input  logic             clr_err,
    output logic [7:0]       en_reg_out_7_0,
    output logic [7:0]       en_reg_out_15_8,
    output logic [7:0]       en_reg_pwm_7_0,
    output logic [7:0]       en_reg_pwm_15_8,
    output logic [7:0]       pwm_duty_cycle,
    output logic             wr_valid,
    output logic [2:0]       wr_addr,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [2:0]       err_flags,
    output logic             busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_DATA   = 3'd2,
        ST_END    = 3'd3,
        ST_COMMIT = 3'd4,
        ST_DRAIN  = 3'd5
    } state_t;

    localparam logic [2:0]      C_ERR_LEN  = 3'b001;
    localparam logic [2:0]      C_ERR_ADDR = 3'b010;
    localparam logic [2:0]      C_ERR_TO   = 3'b100;
    // Expiry fires on the edge at which the count would reach TIMEOUT_CYCLES.
    localparam logic [TO_W-1:0] C_TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          r_state;
    logic [7:0]      r_cmd;
    logic [7:0]      r_data;
    logic [TO_W-1:0] r_to_cnt;

    logic            w_to_expire;
    logic [2:0]      w_err_keep;

    assign w_to_expire = (r_to_cnt == C_TO_LAST);
    // Clear first; any flag set in the same cycle is OR-ed on top, so set wins.
    assign w_err_keep  = clr_err ? 3'b000 : err_flags;
    assign busy        = (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_cmd           <= '0;
            r_data          <= '0;
            r_to_cnt        <= '0;
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
            wr_valid        <= 1'b0;
            wr_addr         <= '0;
            frame_cnt       <= '0;
            err_flags       <= '0;
        end else begin
            wr_valid  <= 1'b0;
            err_flags <= w_err_keep;

            if (ncs_fall && (r_state != ST_IDLE)) begin
                // A new frame start aborts whatever was in flight.
                r_state   <= ST_CMD;
                r_to_cnt  <= '0;
                err_flags <= w_err_keep | C_ERR_LEN;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (ncs_fall) begin
                            r_state  <= ST_CMD;
                            r_to_cnt <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (ncs_rise) begin
                            r_state   <= ST_IDLE;
                            err_flags <= w_err_keep | C_ERR_LEN;
                        end else if (byte_valid) begin
                            r_cmd    <= byte_data;
                            r_to_cnt <= '0;
                            r_state  <= ST_DATA;
                        end else if (w_to_expire) begin
                            r_state   <= ST_DRAIN;
                            err_flags <= w_err_keep | C_ERR_TO;
                        end else begin
                            r_to_cnt <= r_to_cnt + TO_W'(1);
                        end
                    end
                    ST_DATA: begin
                        if (byte_valid) begin
                            r_data   <= byte_data;
                            r_to_cnt <= '0;
                            r_state  <= ncs_rise ? ST_COMMIT : ST_END;
                        end else if (ncs_rise) begin
                            r_state   <= ST_IDLE;
                            err_flags <= w_err_keep | C_ERR_LEN;
                        end else if (w_to_expire) begin
                            r_state   <= ST_DRAIN;
                            err_flags <= w_err_keep | C_ERR_TO;
                        end else begin
                            r_to_cnt <= r_to_cnt + TO_W'(1);
                        end
                    end
                    ST_END: begin
                        if (byte_valid) begin
                            // Third byte: frame is too long, never commits.
                            r_to_cnt  <= '0;
                            err_flags <= w_err_keep | C_ERR_LEN;
                            r_state   <= ncs_rise ? ST_IDLE : ST_DRAIN;
                        end else if (ncs_rise) begin
                            r_state <= ST_COMMIT;
                        end else if (w_to_expire) begin
                            r_state   <= ST_DRAIN;
                            err_flags <= w_err_keep | C_ERR_TO;
                        end else begin
                            r_to_cnt <= r_to_cnt + TO_W'(1);
                        end
                    end
                    ST_COMMIT: begin
                        r_state <= ST_IDLE;
                        if (r_cmd[7] && (r_cmd[6:0] < 7'd5)) begin
                            case (r_cmd[2:0])
                                3'd0:    en_reg_out_7_0  <= r_data;
                                3'd1:    en_reg_out_15_8 <= r_data;
                                3'd2:    en_reg_pwm_7_0  <= r_data;
                                3'd3:    en_reg_pwm_15_8 <= r_data;
                                default: pwm_duty_cycle  <= r_data;
                            endcase
                            wr_valid  <= 1'b1;
                            wr_addr   <= r_cmd[2:0];
                            frame_cnt <= frame_cnt + CNT_W'(1);
                        end else begin
                            err_flags <= w_err_keep | C_ERR_ADDR;
                        end
                    end
                    ST_DRAIN: begin
                        if (ncs_rise) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
